// File: rtl/zap_wb_xbar_dec_if.sv
// Wishbone bus bundle for the single-master, N-slave address decoder.
// Signal names follow the decoder's point of view (i_ = into the decoder, o_ = out of it).
interface zap_wb_xbar_dec_if #(
   parameter int NUM_SLAVES = 4
);
   logic                     i_wb_cyc;
   logic                     i_wb_stb;
   logic                     i_wb_we;
   logic [31:0]              i_wb_adr;
   logic [31:0]              i_wb_dat;
   logic [3:0]               i_wb_sel;
   logic [2:0]               i_wb_cti;
   logic [31:0]              o_wb_dat;
   logic                     o_wb_ack;
   logic                     o_wb_err;
   logic [NUM_SLAVES-1:0]    o_s_cyc;
   logic [NUM_SLAVES-1:0]    o_s_stb;
   logic [31:0]              o_s_adr;
   logic [31:0]              o_s_dat;
   logic [3:0]               o_s_sel;
   logic                     o_s_we;
   logic [2:0]               o_s_cti;
   logic [NUM_SLAVES*32-1:0] i_s_dat;
   logic [NUM_SLAVES-1:0]    i_s_ack;
   logic [NUM_SLAVES-1:0]    i_s_err;

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel, i_wb_cti,
      output o_wb_dat, o_wb_ack, o_wb_err,
      output o_s_cyc, o_s_stb, o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cti,
      input  i_s_dat, i_s_ack, i_s_err
   );

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel, i_wb_cti,
      input  o_wb_dat, o_wb_ack, o_wb_err,
      input  o_s_cyc, o_s_stb, o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cti,
      output i_s_dat, i_s_ack, i_s_err
   );
endinterface

// File: rtl/zap_wb_xbar_dec.sv
// Wishbone B3 single-master address decoder with base/mask windows, per-cycle slave
// locking, unmapped/timeout bus errors and first-fault capture with interrupt.
module zap_wb_xbar_dec #(
   parameter int                       NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'hFFFFFFE0, 32'hFFFFFFC0, 32'hFFFFFFA0, 32'h0},
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFFFFE0, 32'hFFFFFFE0, 32'hFFFFFFE0, 32'h0},
   parameter int                       TIMEOUT    = 255
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   zap_wb_xbar_dec_if.slave   bus,
   input  logic               i_err_clr,
   output logic               o_err_valid,
   output logic [31:0]        o_err_adr,
   output logic [1:0]         o_err_code
);
   localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_UNMAP, S_ABORT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] w_hit_idx;
   logic [SEL_W-1:0] w_cur;
   logic             w_hit;
   logic             w_req;
   logic             w_route;
   logic             w_s_ack;
   logic             w_s_err;
   logic [31:0]      w_s_dat;
   logic             w_cnt_en;
   logic             w_timeout;
   logic [31:0]      r_wd_ctr;
   logic [31:0]      w_wd_nxt;
   logic             w_fault;
   logic [1:0]       w_fault_code;

   assign bus.o_s_adr = bus.i_wb_adr;
   assign bus.o_s_dat = bus.i_wb_dat;
   assign bus.o_s_sel = bus.i_wb_sel;
   assign bus.o_s_we  = bus.i_wb_we;
   assign bus.o_s_cti = bus.i_wb_cti;
   assign w_req       = bus.i_wb_cyc & bus.i_wb_stb;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if ((bus.i_wb_adr & SLAVE_MASK[k*32 +: 32]) == SLAVE_BASE[k*32 +: 32]) begin
            w_hit     = 1'b1;
            w_hit_idx = SEL_W'(k);
         end
      end
   end

   always_comb begin
      w_route = 1'b0;
      w_cur   = r_sel;
      if (r_state == S_ACTIVE) begin
         w_route = 1'b1;
      end else if (r_state == S_IDLE && w_req && w_hit) begin
         w_route = 1'b1;
         w_cur   = w_hit_idx;
      end
      w_s_ack = bus.i_s_ack[w_cur];
      w_s_err = bus.i_s_err[w_cur];
      w_s_dat = bus.i_s_dat[32*int'(w_cur) +: 32];
   end

   // The watchdog also counts the first (IDLE) strobe cycle, so a silent slave
   // errors on strobe cycle TIMEOUT+1.
   assign w_cnt_en  = (TIMEOUT != 0) && w_route && bus.i_wb_stb && !w_s_ack && !w_s_err;
   assign w_timeout = w_cnt_en && (r_wd_ctr == 32'(TIMEOUT - 1));
   assign w_wd_nxt  = (w_cnt_en && w_state_nxt == S_ACTIVE) ? r_wd_ctr + 32'd1 : 32'd0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (!w_hit)         w_state_nxt = S_UNMAP;
               else if (w_timeout) w_state_nxt = S_ABORT;
               else                w_state_nxt = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (!bus.i_wb_cyc)  w_state_nxt = S_IDLE;
            else if (w_timeout) w_state_nxt = S_ABORT;
         end
         default: begin
            if (!bus.i_wb_cyc) w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.o_s_cyc  = '0;
      bus.o_s_stb  = '0;
      bus.o_wb_ack = 1'b0;
      bus.o_wb_err = 1'b0;
      bus.o_wb_dat = 32'd0;
      if (w_route) begin
         bus.o_s_cyc[w_cur] = bus.i_wb_cyc;
         bus.o_s_stb[w_cur] = bus.i_wb_stb;
         bus.o_wb_ack       = w_s_ack;
         bus.o_wb_err       = w_s_err;
         bus.o_wb_dat       = w_s_dat;
      end else if (r_state == S_UNMAP || r_state == S_ABORT) begin
         bus.o_wb_err = w_req;
      end
      if (!i_reset_n) begin
         bus.o_s_cyc  = '0;
         bus.o_s_stb  = '0;
         bus.o_wb_ack = 1'b0;
         bus.o_wb_err = 1'b0;
      end
   end

   always_comb begin
      w_fault      = 1'b1;
      w_fault_code = 2'b00;
      if (r_state == S_IDLE && w_req && !w_hit) w_fault_code = 2'b01;
      else if (w_timeout)                       w_fault_code = 2'b10;
      else if (w_route && w_s_err)              w_fault_code = 2'b11;
      else                                      w_fault = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state     <= S_IDLE;
         r_sel       <= '0;
         r_wd_ctr    <= 32'd0;
         o_err_valid <= 1'b0;
         o_err_adr   <= 32'd0;
         o_err_code  <= 2'b00;
      end else begin
         r_state  <= w_state_nxt;
         r_wd_ctr <= w_wd_nxt;
         if (r_state == S_IDLE && w_req && w_hit) r_sel <= w_hit_idx;
         // A fault arriving with the clear wins over the clear.
         if (w_fault && (!o_err_valid || i_err_clr)) begin
            o_err_valid <= 1'b1;
            o_err_adr   <= bus.i_wb_adr;
            o_err_code  <= w_fault_code;
         end else if (i_err_clr) begin
            o_err_valid <= 1'b0;
            o_err_adr   <= 32'd0;
            o_err_code  <= 2'b00;
         end
      end
   end
endmodule

// File: tb/tb_zap_wb_xbar_dec.sv
// Directed plus randomized bench for zap_wb_xbar_dec against a window/fault reference model.
module tb_zap_wb_xbar_dec;
   localparam int NS  = 4;
   localparam int TMO = 4;
   // Slot 3 overlaps slots 1 and 2, so priority decides; >= 0x10000 is unmapped.
   localparam logic [NS*32-1:0] P_BASE = {32'h0000_8000, 32'h0000_8020, 32'h0000_8000, 32'h0000_0000};
   localparam logic [NS*32-1:0] P_MASK = {32'hFFFF_8000, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_8000};

   logic        clk;
   logic        rst_n;
   logic        err_clr;
   logic        err_valid;
   logic [31:0] err_adr;
   logic [1:0]  err_code;

   zap_wb_xbar_dec_if #(.NUM_SLAVES(NS)) bus ();

   zap_wb_xbar_dec #(
      .NUM_SLAVES (NS),
      .SLAVE_BASE (P_BASE),
      .SLAVE_MASK (P_MASK),
      .TIMEOUT    (TMO)
   ) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .bus         (bus),
      .i_err_clr   (err_clr),
      .o_err_valid (err_valid),
      .o_err_adr   (err_adr),
      .o_err_code  (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk;
   int          n_err;
   logic        m_valid;
   logic [31:0] m_adr;
   logic [1:0]  m_code;
   logic [31:0] sd [NS];

   function automatic int model_decode(input logic [31:0] a);
      for (int k = 0; k < NS; k++)
         if ((a & P_MASK[k*32 +: 32]) == P_BASE[k*32 +: 32]) return k;
      return -1;
   endfunction

   task automatic model_clear();
      m_valid = 1'b0;
      m_adr   = 32'd0;
      m_code  = 2'b00;
   endtask

   task automatic model_fault(input logic [31:0] a, input logic [1:0] code);
      if (!m_valid) begin
         m_valid = 1'b1;
         m_adr   = a;
         m_code  = code;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic chk_fault(input string tag);
      chk({tag, "_vld"},  32'(err_valid), 32'(m_valid));
      chk({tag, "_adr"},  err_adr, m_adr);
      chk({tag, "_code"}, 32'(err_code), 32'(m_code));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic load_sdat();
      for (int j = 0; j < NS; j++) begin
         sd[j] = $urandom;
         bus.i_s_dat[j*32 +: 32] = sd[j];
      end
   endtask

   task automatic bus_idle();
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      bus.i_s_ack  = '0;
      bus.i_s_err  = '0;
   endtask

   // rsp: 0 = ack, 1 = err, 2 = ack and err together; lat = silent cycles before response.
   task automatic access(input logic [31:0] a, input int lat, input int rsp, input logic clr);
      int          k;
      logic [31:0] exp_stb;
      k = model_decode(a);
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      bus.i_wb_adr = a;
      bus.i_wb_we  = 1'($urandom);
      bus.i_wb_dat = $urandom;
      bus.i_wb_sel = 4'hF;
      bus.i_wb_cti = 3'b000;
      load_sdat();
      err_clr = clr;
      if (clr) model_clear();
      if (k < 0) begin
         settle();
         chk("unm_stb_c0", 32'(bus.o_s_stb), 32'd0);
         chk("unm_err_c0", 32'(bus.o_wb_err), 32'd0);
         model_fault(a, 2'b01);
         tick();
         err_clr = 1'b0;
         settle();
         chk("unm_err_c1", 32'(bus.o_wb_err), 32'd1);
         chk("unm_stb_c1", 32'(bus.o_s_stb), 32'd0);
         chk("unm_dat", bus.o_wb_dat, 32'd0);
         tick();
      end else begin
         exp_stb = 32'd1 << k;
         for (int c = 0; c <= lat; c++) begin
            bus.i_s_ack = (c == lat && rsp != 1) ? NS'(exp_stb) : '0;
            bus.i_s_err = (c == lat && rsp != 0) ? NS'(exp_stb) : '0;
            settle();
            chk("stb", 32'(bus.o_s_stb), exp_stb);
            chk("cyc", 32'(bus.o_s_cyc), exp_stb);
            chk("bcast_adr", bus.o_s_adr, a);
            chk("ack", 32'(bus.o_wb_ack), 32'(c == lat && rsp != 1));
            chk("err", 32'(bus.o_wb_err), 32'(c == lat && rsp != 0));
            chk("rdat", bus.o_wb_dat, sd[k]);
            if (c == lat && rsp != 0) model_fault(a, 2'b11);
            tick();
            err_clr = 1'b0;
         end
      end
      bus_idle();
      settle();
      chk("idle_stb", 32'(bus.o_s_stb), 32'd0);
      chk_fault("post");
      tick();
   endtask

   task automatic pulse_clear();
      err_clr = 1'b1;
      model_clear();
      tick();
      err_clr = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] win_adr [4];
      n_chk   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      err_clr = 1'b0;
      bus.i_wb_cyc = 1'b0;
      bus.i_wb_stb = 1'b0;
      bus.i_wb_we  = 1'b0;
      bus.i_wb_adr = 32'd0;
      bus.i_wb_dat = 32'd0;
      bus.i_wb_sel = 4'h0;
      bus.i_wb_cti = 3'b000;
      bus.i_s_dat  = '0;
      bus.i_s_ack  = '0;
      bus.i_s_err  = '0;
      model_clear();

      // Reset forces strobes and responses low even with a live request.
      tick();
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      bus.i_wb_adr = 32'h0000_0100;
      bus.i_s_ack  = '1;
      bus.i_s_err  = '1;
      settle();
      chk("rst_stb", 32'(bus.o_s_stb), 32'd0);
      chk("rst_cyc", 32'(bus.o_s_cyc), 32'd0);
      chk("rst_ack", 32'(bus.o_wb_ack), 32'd0);
      chk("rst_err", 32'(bus.o_wb_err), 32'd0);
      tick();
      chk_fault("rst");
      bus_idle();
      tick();
      rst_n = 1'b1;
      tick();

      // One zero-latency read per window; 0x8004 exercises lowest-index priority.
      win_adr[0] = 32'h0000_0100;
      win_adr[1] = 32'h0000_8004;
      win_adr[2] = 32'h0000_8028;
      win_adr[3] = 32'h0000_9000;
      for (int i = 0; i < 4; i++) access(win_adr[i], 0, 0, 1'b0);

      // Burst from slave 0 that walks into slave 1's window stays on slave 0.
      a = 32'h0000_7FF8;
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      bus.i_wb_cti = 3'b010;
      for (int b = 0; b < 4; b++) begin
         bus.i_wb_adr = a;
         load_sdat();
         bus.i_s_ack = NS'(1);
         settle();
         chk("burst_stb", 32'(bus.o_s_stb), 32'd1);
         chk("burst_ack", 32'(bus.o_wb_ack), 32'd1);
         chk("burst_dat", bus.o_wb_dat, sd[0]);
         tick();
         a = a + 32'd4;
      end
      bus.i_wb_cti = 3'b000;
      bus_idle();
      tick();

      // Unmapped access.
      access(32'h0001_0000, 0, 0, 1'b0);
      chk("unm_code", 32'(err_code), 32'd1);
      pulse_clear();

      // Silent slave 2: strobe cycles 1..4 route, cycle 5 errors with strobe dropped.
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      bus.i_wb_adr = 32'h0000_8024;
      for (int c = 0; c < TMO; c++) begin
         settle();
         chk("tmo_stb", 32'(bus.o_s_stb), 32'd4);
         chk("tmo_err_early", 32'(bus.o_wb_err), 32'd0);
         tick();
      end
      settle();
      chk("tmo_stb_drop", 32'(bus.o_s_stb), 32'd0);
      chk("tmo_err", 32'(bus.o_wb_err), 32'd1);
      model_fault(32'h0000_8024, 2'b10);
      tick();
      bus_idle();
      settle();
      chk("tmo_err_clr", 32'(bus.o_wb_err), 32'd0);
      tick();
      chk_fault("tmo");
      access(32'h0000_8028, 1, 0, 1'b0);
      pulse_clear();

      // First fault retained; clear together with a third fault captures the third.
      access(32'h0000_8008, 2, 1, 1'b0);
      access(32'h0002_0000, 0, 0, 1'b0);
      chk("keep_code", 32'(err_code), 32'd3);
      access(32'h0003_0004, 0, 0, 1'b1);
      chk("third_adr", err_adr, 32'h0003_0004);
      pulse_clear();
      access(32'h0000_0040, 3, 2, 1'b0);
      pulse_clear();

      // Randomized traffic against the reference model.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0:       a = $urandom & 32'h0000_7FFC;
            1:       a = 32'h0000_8000 | ($urandom & 32'h1C);
            2:       a = 32'h0000_8020 | ($urandom & 32'h1C);
            3:       a = 32'h0000_9000 + ($urandom & 32'h0000_6FFC);
            default: a = $urandom | 32'h0001_0000;
         endcase
         access(a, int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0) ? 1 : 0,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      end

      // Reset mid-burst with a fault pending.
      access(32'h0005_0000, 0, 0, 1'b0);
      bus.i_wb_cyc = 1'b1;
      bus.i_wb_stb = 1'b1;
      bus.i_wb_cti = 3'b010;
      bus.i_wb_adr = 32'h0000_8010;
      bus.i_s_ack  = NS'(2);
      tick();
      bus.i_wb_adr = 32'h0000_8014;
      rst_n = 1'b0;
      settle();
      chk("mrst_stb", 32'(bus.o_s_stb), 32'd0);
      chk("mrst_cyc", 32'(bus.o_s_cyc), 32'd0);
      chk("mrst_ack", 32'(bus.o_wb_ack), 32'd0);
      chk("mrst_err", 32'(bus.o_wb_err), 32'd0);
      tick();
      model_clear();
      bus.i_wb_cti = 3'b000;
      bus_idle();
      settle();
      chk_fault("mrst");
      tick();
      rst_n = 1'b1;
      access(32'h0000_9000, 0, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
